// File: rtl/imm_decode_stage.sv
// immtypes_pkg: immediate format selector shared with the combinational immgen.
// imm_decode_stage: registered immediate generator with a 2-entry skid buffer.
//   Decodes the immediate type from the opcode (AUTO_SEL=1) or takes it from
//   in_imm_sel (AUTO_SEL=0), sign-extends to XLEN, and produces Zicsr zimm.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   flush                          drop buffered entries and the current input
//   in_valid/in_ready              upstream handshake (in_ready is registered state only)
//   in_instr, in_imm_sel, in_tag   instruction word, manual type select, sideband tag
//   out_valid/out_ready            downstream handshake
//   out_imm, out_imm_sel           generated immediate and its resolved type
//   out_zimm, out_illegal, out_tag CSR zimm flag, no-immediate opcode flag, tag
package immtypes_pkg;
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;
endpackage

module imm_decode_stage
  import immtypes_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AUTO_SEL = 1,
  parameter int unsigned ZICSR    = 1,
  parameter int unsigned TAG_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  imm_sel_e         in_imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output imm_sel_e         out_imm_sel,
  output logic             out_zimm,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_sel_e         sel;
    logic             zimm;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  // ---------------- decode ----------------
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z, fmt_imm;
  imm_sel_e        dec_sel;
  logic            dec_zimm, dec_illegal;
  entry_t          dec_entry;

  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                in_instr[30:21], 1'b0}));
  assign imm_z = XLEN'(in_instr[19:15]);

  always_comb begin
    dec_sel     = IMM_I;
    dec_zimm    = 1'b0;
    dec_illegal = 1'b0;
    if (AUTO_SEL != 0) begin
      case (in_instr[6:0])
        7'b0010011, 7'b0000011, 7'b1100111: dec_sel = IMM_I;
        7'b0011011:                         dec_illegal = (XLEN != 64);
        7'b0100011:                         dec_sel = IMM_S;
        7'b1100011:                         dec_sel = IMM_B;
        7'b0110111, 7'b0010111:             dec_sel = IMM_U;
        7'b1101111:                         dec_sel = IMM_J;
        7'b1110011: begin
          if ((ZICSR != 0) && in_instr[14]) dec_zimm = 1'b1;
          else                               dec_illegal = 1'b1;
        end
        default:                            dec_illegal = 1'b1;
      endcase
    end else begin
      dec_sel = in_imm_sel;
    end

    case (dec_sel)
      IMM_I:   fmt_imm = imm_i;
      IMM_S:   fmt_imm = imm_s;
      IMM_B:   fmt_imm = imm_b;
      IMM_U:   fmt_imm = imm_u;
      IMM_J:   fmt_imm = imm_j;
      default: fmt_imm = '0;
    endcase

    dec_entry.sel     = dec_sel;
    dec_entry.zimm    = dec_zimm;
    dec_entry.illegal = dec_illegal;
    dec_entry.tag     = in_tag;
    if (dec_illegal)   dec_entry.imm = '0;
    else if (dec_zimm) dec_entry.imm = imm_z;
    else               dec_entry.imm = fmt_imm;
  end

  // ---------------- skid buffer ----------------
  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic   accept, main_free;

  assign in_ready  = ~skid_v_q;
  assign accept    = in_valid & ~skid_v_q;
  assign main_free = ~main_v_q | out_ready;

  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (main_free) begin
      // The skid entry is older than anything offered now; while it is full
      // in_ready is low, so no accept can race it into main.
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = accept;
        if (accept) main_d = dec_entry;
      end
    end else if (accept) begin
      skid_d   = dec_entry;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign out_valid   = main_v_q;
  assign out_imm     = main_q.imm;
  assign out_imm_sel = main_q.sel;
  assign out_zimm    = main_q.zimm;
  assign out_illegal = main_q.illegal;
  assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: three instances (RV32 auto-decode,
// RV64 auto-decode, RV32 manual select) share one input stream.
module tb_imm_decode_stage;
  import immtypes_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_tag;
  imm_sel_e    in_imm_sel;

  logic        in_ready, out_valid, out_zimm, out_illegal;
  logic [31:0] out_imm, out_tag;
  imm_sel_e    out_imm_sel;

  logic        in_ready64, out_valid64, out_zimm64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;
  imm_sel_e    out_imm_sel64;

  logic        in_readym, out_validm, out_zimmm, out_illegalm;
  logic [31:0] out_immm, out_tagm;
  imm_sel_e    out_imm_selm;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  imm_decode_stage #(.XLEN(32), .AUTO_SEL(1), .ZICSR(1), .TAG_W(32)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_imm_sel(out_imm_sel), .out_zimm(out_zimm), .out_illegal(out_illegal),
    .out_tag(out_tag));

  imm_decode_stage #(.XLEN(64), .AUTO_SEL(1), .ZICSR(1), .TAG_W(32)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_imm_sel(out_imm_sel64), .out_zimm(out_zimm64), .out_illegal(out_illegal64),
    .out_tag(out_tag64));

  imm_decode_stage #(.XLEN(32), .AUTO_SEL(0), .ZICSR(1), .TAG_W(32)) u_dutm (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_readym),
    .in_instr(in_instr), .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(out_validm), .out_ready(out_ready), .out_imm(out_immm),
    .out_imm_sel(out_imm_selm), .out_zimm(out_zimmm), .out_illegal(out_illegalm),
    .out_tag(out_tagm));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    logic [70:0] got, exp_v;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'hAB; in_imm_sel = IMM_I;
    step();
    step();
    got   = {out_valid, out_imm, out_imm_sel, out_zimm, out_illegal, out_tag, in_ready};
    exp_v = {1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b1};
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", got, exp_v);
    end
    rst = 1'b0; in_valid = 1'b0;
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_input_ignored: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_decode();
    logic [31:0] ins  [12] = '{32'hFFF00093, 32'hFE512C23, 32'hFE000EE3, 32'h12345017,
                               32'hFFFFF06F, 32'h3007D073, 32'h0000000B, 32'h7FF02083,
                               32'hFFF0009B, 32'h30079073, 32'h80008067, 32'h800002B7};
    logic [31:0] imm  [12] = '{32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h12345000,
                               32'hFFFFFFFE, 32'h0000000F, 32'h00000000, 32'h000007FF,
                               32'h00000000, 32'h00000000, 32'hFFFFF800, 32'h80000000};
    logic [2:0]  sel  [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0,
                               3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3};
    logic        zim  [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    logic        ill  [12] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0};
    logic [68:0] got, exp_v;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_instr = ins[i]; in_tag = 32'(100 + i);
      step();
      in_valid = 1'b0;
      got   = {out_valid, out_imm, out_imm_sel, out_zimm, out_illegal, out_tag};
      exp_v = {1'b1, imm[i], sel[i], zim[i], ill[i], 32'(100 + i)};
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL decode32[%0d] instr=%h: got %h expected %h", i, ins[i], got, exp_v);
      end
    end
    drain();
  endtask

  task automatic test_xlen64();
    logic [31:0] ins [3] = '{32'h800002B7, 32'hFFF0009B, 32'hFE000EE3};
    logic [63:0] imm [3] = '{64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC};
    logic [2:0]  sel [3] = '{3'd3, 3'd0, 3'd2};
    logic [69:0] got, exp_v;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = ins[i]; in_tag = 32'(200 + i);
      step();
      in_valid = 1'b0;
      got   = {out_valid64, out_imm64, out_imm_sel64, out_zimm64, out_illegal64};
      exp_v = {1'b1, imm[i], sel[i], 1'b0, 1'b0};
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL decode64[%0d] instr=%h: got %h expected %h", i, ins[i], got, exp_v);
      end
    end
    drain();
  endtask

  task automatic test_manual_sel();
    logic [31:0] ins [5] = '{32'hFFF00093, 32'hFFF0009B, 32'h3007D073, 32'hFFF00093, 32'h0000100B};
    logic [2:0]  sel [5] = '{3'd1, 3'd3, 3'd0, 3'd7, 3'd4};
    logic [31:0] imm [5] = '{32'hFFFFFFE1, 32'hFFF00000, 32'h00000300, 32'h0, 32'h00001000};
    logic [37:0] got, exp_v;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_instr = ins[i]; in_imm_sel = imm_sel_e'(sel[i]);
      in_tag = 32'(300 + i);
      step();
      in_valid = 1'b0;
      got   = {out_validm, out_immm, out_imm_selm, out_zimmm, out_illegalm};
      exp_v = {1'b1, imm[i], sel[i], 1'b0, 1'b0};
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL manual_sel[%0d] sel=%0d: got %h expected %h", i, sel[i], got, exp_v);
      end
    end
    in_imm_sel = IMM_I;
    drain();
  endtask

  task automatic test_backpressure();
    // expected {out_valid, out_tag[7:0], in_ready} after each edge
    logic        rdy [6] = '{0, 0, 0, 1, 1, 1};
    logic        vin [6] = '{1, 1, 1, 1, 1, 0};
    logic [31:0] tag [6] = '{1, 2, 3, 3, 3, 3};
    logic [9:0]  exp_t [6] = '{{1'b1, 8'd1, 1'b1}, {1'b1, 8'd1, 1'b0}, {1'b1, 8'd1, 1'b0},
                               {1'b1, 8'd2, 1'b1}, {1'b1, 8'd3, 1'b1}, {1'b0, 8'd3, 1'b1}};
    logic [9:0]  got;
    in_instr = 32'h00000013;
    for (int i = 0; i < 6; i++) begin
      out_ready = rdy[i]; in_valid = vin[i]; in_tag = tag[i];
      step();
      got = {out_valid, out_tag[7:0], in_ready};
      n_tests++;
      if (got !== exp_t[i]) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: got {v,tag,rdy}=%h expected %h", i, got, exp_t[i]);
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [65:0] got, exp_v;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_tag = 32'(16 + k);
      in_instr = (32'(k) << 20) | 32'h00000013;
      step();
      got   = {out_valid, out_tag, out_imm, in_ready};
      exp_v = {1'b1, 32'(16 + k), 32'(k), 1'b1};
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", k, got, exp_v);
      end
    end
    in_valid = 1'b0;
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_end: out_valid got %b expected 0", out_valid);
    end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_instr = 32'h00000013;
    in_valid = 1'b1; in_tag = 32'h21; step();
    in_tag = 32'h22; step();
    n_tests++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_fill: got {v,rdy}=%b expected 10", {out_valid, in_ready});
    end
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_tag = 32'h23;
    step();
    n_tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_clear: got {v,rdy}=%b expected 01", {out_valid, in_ready});
    end
    flush = 1'b0; in_valid = 1'b0;
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drop: out_valid got %b expected 0", out_valid);
    end
    in_valid = 1'b1; in_tag = 32'h24;
    step();
    in_valid = 1'b0;
    n_tests++;
    if ({out_valid, out_tag} !== {1'b1, 32'h24}) begin
      n_fail++;
      $display("FAIL flush_resume: got %h expected %h", {out_valid, out_tag}, {1'b1, 32'h24});
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_xlen64();
    test_manual_sel();
    test_backpressure();
    test_back_to_back();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
